// File: rtl/latch_load_ctrl_pkg.sv
// Shared state encoding and timer sizing helpers for the latch load controller.
package latch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SETUP = ST_SETUP,
        S_PULSE = ST_PULSE,
        S_HOLD  = ST_HOLD
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Timer must hold the largest reload value (max-1); sized for max to stay safe.
    function automatic int cyc_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/latch_load_ctrl_if.sv
// Valid/ready word handshake from the data source into the latch load controller.
interface latch_load_ctrl_if #(parameter int WIDTH = 1) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/latch_load_ctrl.sv
// Drives a level-sensitive D latch with a registered setup / enable-pulse / hold sequence.
// Optional latch readback check is enabled by defining LATCH_READBACK_EN.
//
// state  | meaning
// IDLE   | waiting for a word, in_ready=1
// SETUP  | Din stable, enable low, SETUP_CYC cycles
// PULSE  | enable high, PULSE_CYC cycles
// HOLD   | enable low, Din held, HOLD_CYC cycles
module latch_load_ctrl
    import latch_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    latch_load_ctrl_if.slave  bus,
    output logic [WIDTH-1:0]  Din,
    output logic              enable,
    output logic              busy,
    output logic [CNT_W-1:0]  load_count
`ifdef LATCH_READBACK_EN
    ,
    input  logic [WIDTH-1:0]  Q,
    output logic              rb_valid,
    output logic              rb_err
`endif
);

    localparam int CYC_W = cyc_w(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC));

    if (SETUP_CYC < 1) begin : g_bad_setup
        $error("latch_load_ctrl: SETUP_CYC must be >= 1");
    end
    if (PULSE_CYC < 1) begin : g_bad_pulse
        $error("latch_load_ctrl: PULSE_CYC must be >= 1");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("latch_load_ctrl: HOLD_CYC must be >= 1");
    end

    state_e            state_q;
    logic [CYC_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  din_q;
    logic              enable_q;
    logic              in_ready_q;
    logic              busy_q;
    logic [CNT_W-1:0]  load_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            din_q        <= '0;
            enable_q     <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            load_count_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        din_q      <= bus.in_data;
                        cnt_q      <= CYC_W'(SETUP_CYC - 1);
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == '0) begin
                        enable_q <= 1'b1;
                        cnt_q    <= CYC_W'(PULSE_CYC - 1);
                        state_q  <= S_PULSE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        enable_q     <= 1'b0;
                        cnt_q        <= CYC_W'(HOLD_CYC - 1);
                        load_count_q <= load_count_q + CNT_W'(1);
                        state_q      <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef LATCH_READBACK_EN
    logic rb_valid_q;
    logic rb_err_q;

    // Q is compared on the final HOLD cycle, when the latch has settled and Din is still held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_valid_q <= 1'b0;
            rb_err_q   <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;
            if (state_q == S_HOLD && cnt_q == '0) begin
                rb_valid_q <= 1'b1;
                rb_err_q   <= (Q != din_q);
            end
        end
    end

    assign rb_valid = rb_valid_q;
    assign rb_err   = rb_err_q;
`endif

    assign bus.in_ready = in_ready_q;
    assign Din          = din_q;
    assign enable       = enable_q;
    assign busy         = busy_q;
    assign load_count   = load_count_q;

endmodule

// File: tb/tb_latch_load_ctrl.sv
// Directed bench for latch_load_ctrl with a behavioural D latch downstream (CNT_W=2 to exercise wrap).
module tb_latch_load_ctrl;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       en;
    logic       busy;
    logic [1:0] cnt;
    logic       lq;
    int         checks;
    int         errors;
    int         glitches;
    logic [2:0] words;

    latch_load_ctrl_if #(.WIDTH(1)) bus ();

`ifdef LATCH_READBACK_EN
    logic rb_inv;
    logic q_fb;
    logic rb_valid;
    logic rb_err;
    assign q_fb = rb_inv ? ~lq : lq;
`endif

    latch_load_ctrl #(
        .WIDTH(1), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1), .CNT_W(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .Din        (din),
        .enable     (en),
        .busy       (busy),
        .load_count (cnt)
`ifdef LATCH_READBACK_EN
        ,
        .Q          (q_fb),
        .rb_valid   (rb_valid),
        .rb_err     (rb_err)
`endif
    );

    always_latch begin
        if (en) lq = din;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(din) begin
        if (en === 1'b1) glitches++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    // One isolated load with cycle-by-cycle checks; accept edge is T.
    task automatic do_load(input logic d, input logic [1:0] exp_cnt);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        step();
        chk("acc_ready", {31'b0, bus.in_ready}, 0);
        chk("acc_busy", {31'b0, busy}, 1);
        chk("acc_din", {31'b0, din}, {31'b0, d});
        chk("acc_en", {31'b0, en}, 0);
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
        step();
        chk("t1_en", {31'b0, en}, 1);
        chk("t1_din", {31'b0, din}, {31'b0, d});
        bus.in_data = d;
        step();
        chk("t2_en", {31'b0, en}, 1);
        chk("t2_ready", {31'b0, bus.in_ready}, 0);
        step();
        chk("t3_en", {31'b0, en}, 0);
        chk("t3_cnt", {30'b0, cnt}, {30'b0, exp_cnt});
        chk("t3_ready", {31'b0, bus.in_ready}, 0);
        step();
        chk("t4_ready", {31'b0, bus.in_ready}, 1);
        chk("t4_busy", {31'b0, busy}, 0);
        chk("t4_din", {31'b0, din}, {31'b0, d});
        chk("t4_latch", {31'b0, lq}, {31'b0, d});
`ifdef LATCH_READBACK_EN
        chk("t4_rb_valid", {31'b0, rb_valid}, 1);
        chk("t4_rb_err", {31'b0, rb_err}, {31'b0, rb_inv});
`endif
        step();
        chk("t5_idle_ready", {31'b0, bus.in_ready}, 1);
`ifdef LATCH_READBACK_EN
        chk("t5_rb_valid", {31'b0, rb_valid}, 0);
        chk("t5_rb_err_hold", {31'b0, rb_err}, {31'b0, rb_inv});
`endif
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        glitches     = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 1'b0;
`ifdef LATCH_READBACK_EN
        rb_inv = 1'b0;
`endif
        #13;
        chk("rst_ready", {31'b0, bus.in_ready}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_en", {31'b0, en}, 0);
        chk("rst_din", {31'b0, din}, 0);
        chk("rst_cnt", {30'b0, cnt}, 0);
        rst_n = 1'b1;
        step();

        do_load(1'b1, 2'd1);

        // Back-to-back with in_valid held high; in_data is scrambled while busy.
        pulse_reset();
        words        = 3'b101;
        bus.in_valid = 1'b1;
        bus.in_data  = words[0];
        for (int k = 0; k < 3; k++) begin
            step();
            chk("b2b_acc_din", {31'b0, din}, {31'b0, words[k]});
            chk("b2b_acc_ready", {31'b0, bus.in_ready}, 0);
            bus.in_data = ~words[k];
            step();
            chk("b2b_en_hi", {31'b0, en}, 1);
            chk("b2b_busy_din", {31'b0, din}, {31'b0, words[k]});
            step();
            chk("b2b_en_hi2", {31'b0, en}, 1);
            chk("b2b_busy_ready", {31'b0, bus.in_ready}, 0);
            bus.in_data = (k < 2) ? words[k+1] : 1'b0;
            step();
            chk("b2b_cnt", {30'b0, cnt}, k + 1);
            chk("b2b_en_lo", {31'b0, en}, 0);
            step();
            chk("b2b_ready", {31'b0, bus.in_ready}, 1);
            chk("b2b_latch", {31'b0, lq}, {31'b0, words[k]});
            if (k == 2) bus.in_valid = 1'b0;
        end
        step();
        chk("b2b_no_accept", {31'b0, bus.in_ready}, 1);
        chk("din_glitches", glitches, 0);

        // Reset while enable is high.
        bus.in_data  = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("mid_en_hi", {31'b0, en}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_en_async", {31'b0, en}, 0);
        chk("mid_ready", {31'b0, bus.in_ready}, 1);
        chk("mid_cnt", {30'b0, cnt}, 0);
        chk("mid_latch_hold", {31'b0, lq}, 1);
        #3;
        rst_n = 1'b1;
        step();
        step();
        chk("mid_stay_idle", {31'b0, en}, 0);
        chk("mid_din", {31'b0, din}, 0);

        // Wrap of the 2-bit load counter; readback sees an inverted latch.
`ifdef LATCH_READBACK_EN
        rb_inv = 1'b1;
`endif
        do_load(1'b0, 2'd1);
        do_load(1'b1, 2'd2);
        do_load(1'b0, 2'd3);
        do_load(1'b1, 2'd0);
        do_load(1'b1, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
